// File: rtl/fir_pkg.sv
// Shared definitions for the FIR output path.
//   ACC_W     : width of the accumulated sum leaving the systolic chain
//   rs_t      : {sat, value} result of the round/saturate helper
//   round_sat : round-half-up, arithmetic shift, clip to a signed out_w range
package fir_pkg;

  localparam int ACC_W = 32;

  typedef struct packed {
    logic                    sat;
    logic signed [ACC_W-1:0] value;
  } rs_t;

  // Value is returned sign-extended to ACC_W; callers keep the low out_w bits.
  function automatic rs_t round_sat(input logic signed [ACC_W-1:0] acc,
                                    input int shift,
                                    input int out_w);
    logic signed [ACC_W:0] ext;
    logic signed [ACC_W:0] one;
    logic signed [ACC_W:0] s;
    logic signed [ACC_W:0] mag;
    logic signed [ACC_W:0] maxv;
    logic signed [ACC_W:0] minv;
    rs_t                   r;
    ext  = {acc[ACC_W-1], acc};
    one  = {{ACC_W{1'b0}}, 1'b1};
    // One extra bit keeps the rounding add from wrapping at the top of range.
    s    = (ext + (one <<< (shift - 1))) >>> shift;
    mag  = one <<< (out_w - 1);
    maxv = mag - one;
    minv = -mag;
    if (s > maxv) begin
      r.sat   = 1'b1;
      r.value = maxv[ACC_W-1:0];
    end else if (s < minv) begin
      r.sat   = 1'b1;
      r.value = minv[ACC_W-1:0];
    end else begin
      r.sat   = 1'b0;
      r.value = s[ACC_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_out_stage_if.sv
// Valid/ready sample stream leaving the FIR output stage.
//   out_data  : signed sample at FIFO head
//   out_valid : head holds a sample
//   out_ready : consumer takes the head this cycle
interface fir_out_stage_if #(
  parameter int OUT_W = 16
) ();
  logic signed [OUT_W-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO.
//   push/din : write din when not full, or when full and pop in the same cycle
//   pop      : remove head (ignored when empty)
//   full     : DEPTH entries held
//   empty    : no entries held
//   head     : oldest entry, combinational; 0 while empty
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  // Extra MSB on each pointer separates full from empty when the indices match.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_en;
  logic             rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is not reset; head is forced to 0 while empty instead.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fir_out_stage.sv
// Output stage of the systolic FIR chain.
//   clk, rst  : clock, asynchronous active-low reset
//   in_valid  : sample enters the chain this cycle
//   yin       : signed sum from the last chain element
//   dout      : rounded/saturated samples, valid/ready, show-ahead
//   overflow  : sticky, a result was dropped on a full FIFO
//   sat       : sticky, a result was clipped
//   drop_cnt  : dropped results, saturating at 255
module fir_out_stage
  import fir_pkg::*;
#(
  parameter int LAT   = 17,
  parameter int SHIFT = 15,
  parameter int OUT_W = 16,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [ACC_W-1:0] yin,
  fir_out_stage_if.master         dout,
  output logic                    overflow,
  output logic                    sat,
  output logic [7:0]              drop_cnt
);

  logic [LAT-1:0]   vsr;
  logic             tag;
  rs_t              rnd;
  logic             unused_rnd_hi;
  logic             rs_valid;
  logic [OUT_W-1:0] rs_data;
  logic             fifo_full;
  logic             fifo_empty;
  logic [OUT_W-1:0] fifo_head;
  logic             drop;

  // Tail of the shift register lines up with the chain's matching sum.
  assign tag = vsr[LAT-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vsr <= '0;
    else      vsr <= (vsr << 1) | LAT'(in_valid);
  end

  assign rnd = round_sat(yin, SHIFT, OUT_W);
  // Bits above OUT_W only repeat the sign after clipping.
  assign unused_rnd_hi = ^rnd.value;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rs_valid <= 1'b0;
      rs_data  <= '0;
      sat      <= 1'b0;
    end else begin
      rs_valid <= tag;
      if (tag) begin
        rs_data <= rnd.value[OUT_W-1:0];
        if (rnd.sat) sat <= 1'b1;
      end
    end
  end

  // A full FIFO is never empty, so a pop request is a real pop here.
  assign drop = rs_valid && fifo_full && !dout.out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rs_valid),
    .din   (rs_data),
    .pop   (dout.out_ready),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  assign dout.out_data  = fifo_head;
  assign dout.out_valid = !fifo_empty;

endmodule

// File: tb/tb_fir_out_stage.sv
// Scoreboard bench for fir_out_stage: directed results are scheduled per clock
// edge, expected samples queued at issue time, and a monitor compares every
// handshake against the queue. A second instance with LAT=17 covers latency.
module tb_fir_out_stage;
  import fir_pkg::*;

  localparam int LAT   = 3;
  localparam int SHIFT = 15;
  localparam int OUT_W = 16;
  localparam int DEPTH = 4;
  localparam int LAT2  = 17;
  localparam logic [31:0] GARB = 32'h7FFF_0000;  // would clip if ever tagged

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic                    in_valid;
  logic signed [ACC_W-1:0] yin;
  logic                    overflow, sat;
  logic [7:0]              drop_cnt;
  fir_out_stage_if #(.OUT_W(OUT_W)) ob ();

  fir_out_stage #(.LAT(LAT), .SHIFT(SHIFT), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .yin      (yin),
    .dout     (ob),
    .overflow (overflow),
    .sat      (sat),
    .drop_cnt (drop_cnt)
  );

  logic                    iv17;
  logic signed [ACC_W-1:0] y17;
  logic                    ovf17, sat17;
  logic [7:0]              dc17;
  fir_out_stage_if #(.OUT_W(OUT_W)) ob17 ();

  fir_out_stage #(.LAT(LAT2), .SHIFT(SHIFT), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut17 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (iv17),
    .yin      (y17),
    .dout     (ob17),
    .overflow (ovf17),
    .sat      (sat17),
    .drop_cnt (dc17)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-edge stimulus schedule: values listed under edge n are sampled at edge n.
  int                edge_n = 0;
  bit                iv_at  [int];
  logic [31:0]       yin_at [int];
  int                ready_from = 0;
  logic signed [15:0] exp_q [$];
  bit                lat_done = 1'b0;

  task automatic drive(input int n);
    in_valid     = iv_at.exists(n);
    yin          = yin_at.exists(n) ? yin_at[n] : GARB;
    ob.out_ready = (n >= ready_from);
  endtask

  initial begin
    drive(1);
    forever begin
      @(posedge clk);
      edge_n++;
      #1;
      drive(edge_n + 1);
    end
  end

  // in_valid at edge e, sum presented for edge e+LAT.
  task automatic issue(input int e, input logic [31:0] y,
                       input logic signed [15:0] expv, input bit keep);
    iv_at[e]        = 1'b1;
    yin_at[e + LAT] = y;
    if (keep) exp_q.push_back(expv);
  endtask

  // Monitor: a handshake seen at the negedge completes at the next posedge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && ob.out_valid && ob.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %0d, expected no sample (t=%0t)",
                   $signed(ob.out_data), $time);
        end else begin
          check("fifo_data", $signed(ob.out_data), exp_q.pop_front());
        end
      end
    end
  end

  // Latency: in_valid sampled at edge 10, sum at edge 27, out_valid after edge 28.
  initial begin
    int first  = -1;
    int nvalid = 0;
    int n;
    iv17           = 1'b0;
    y17            = 32'h1234_5678;
    ob17.out_ready = 1'b1;
    repeat (45) begin
      @(posedge clk);
      #1;
      n    = edge_n + 1;
      iv17 = (n == 10);
      y17  = (n == 27) ? 32'h0000_8000 : 32'h1234_5678;
      @(negedge clk);
      if (ob17.out_valid) begin
        nvalid++;
        if (first < 0) begin
          first = edge_n;
          check("lat_data", $signed(ob17.out_data), 1);
        end
      end
    end
    check("lat_first_edge", first, 28);
    check("lat_valid_cycles", nvalid, 1);
    lat_done = 1'b1;
  end

  initial begin
    int base;
    int nv;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out_valid", ob.out_valid, 0);
    check("rst_out_data", ob.out_data, 0);
    check("rst_overflow", overflow, 0);
    check("rst_sat", sat, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Rounding around +-0.5 LSB
    base = edge_n + 2;
    issue(base,     32'h0000_4000,  1, 1'b1);
    issue(base + 2, 32'h0000_3FFF,  0, 1'b1);
    issue(base + 4, 32'hFFFF_C000,  0, 1'b1);
    issue(base + 6, 32'hFFFF_BFFF, -1, 1'b1);
    repeat (20) @(negedge clk);
    check("round_sat_clear", sat, 0);
    check("round_drained", exp_q.size(), 0);

    // Saturation at both ends
    base = edge_n + 2;
    issue(base, 32'h7FFF_FFFF, 16'sd32767, 1'b1);
    repeat (10) @(negedge clk);
    check("sat_after_max", sat, 1);
    base = edge_n + 2;
    issue(base, 32'h8000_0000, -16'sd32768, 1'b1);
    repeat (10) @(negedge clk);
    check("sat_sticky", sat, 1);
    check("sat_drained", exp_q.size(), 0);

    // Backpressure: 6 results into a 4-deep FIFO, last 2 dropped
    ready_from = 1 << 30;
    base = edge_n + 2;
    for (int k = 0; k < 6; k++)
      issue(base + k, (k + 1) << SHIFT, 16'(k + 1), k < 4);
    repeat (15) @(negedge clk);
    check("bp_overflow", overflow, 1);
    check("bp_drop_cnt", drop_cnt, 2);
    check("bp_out_valid", ob.out_valid, 1);
    check("bp_head_held", $signed(ob.out_data), 1);
    ready_from = edge_n + 2;
    repeat (10) @(negedge clk);
    check("bp_drained", exp_q.size(), 0);
    check("bp_empty_after", ob.out_valid, 0);

    // Full FIFO: 5th result arrives on the same edge as the first pop
    ready_from = 1 << 30;
    base = edge_n + 2;
    for (int k = 0; k < 5; k++)
      issue(base + k, (k + 10) << SHIFT, 16'(k + 10), 1'b1);
    ready_from = base + 4 + LAT + 1;
    repeat (20) @(negedge clk);
    check("fp_drop_cnt", drop_cnt, 2);
    check("fp_overflow", overflow, 1);
    check("fp_drained", exp_q.size(), 0);
    check("fp_empty_after", ob.out_valid, 0);

    // Async reset with 3 entries queued, one in the round stage, one tag in flight
    ready_from = 1 << 30;
    base = edge_n + 2;
    for (int k = 0; k < 5; k++)
      issue(base + k, (k + 20) << SHIFT, 16'(k + 20), 1'b0);
    repeat (8) @(negedge clk);
    check("pre_rst_out_valid", ob.out_valid, 1);
    check("pre_rst_head", $signed(ob.out_data), 20);
    #2 rst = 1'b0;
    #1;
    check("async_out_valid", ob.out_valid, 0);
    check("async_out_data", ob.out_data, 0);
    check("async_overflow", overflow, 0);
    check("async_sat", sat, 0);
    check("async_drop_cnt", drop_cnt, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    ready_from = 0;
    nv = 0;
    repeat (LAT + 5) begin
      @(negedge clk);
      if (ob.out_valid) nv++;
    end
    check("post_rst_idle", nv, 0);

    for (int i = 0; i < 200 && !lat_done; i++) @(negedge clk);
    check("lat_run_done", lat_done, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_out_stage.md
# fir_out_stage

Output stage for the systolic FIR datapath. It sits directly downstream of the last processing element in the chain and tracks which chain outputs carry real results. It rounds and saturates each 32-bit accumulated sum to a narrow sample and buffers the samples in a small FIFO. Samples leave on a valid/ready interface, so the free-running chain never has to stall.

## Interface
Parameters:
- `LAT`, 17: cycles from `in_valid` (sample entering the chain) to the matching sum on `yin`; must be ≥1
- `SHIFT`, 15: fractional bits removed, Q-format of the coefficients; 1..30
- `OUT_W`, 16: output sample width; 2..32
- `DEPTH`, 4: FIFO entries; power of two, ≥2

Ports:
- `clk`, in, 1: clock, all flops on rising edge
- `rst`, in, 1: asynchronous, active-low reset
- `in_valid`, in, 1: sample presented to chain input this cycle
- `yin`, in, 32: signed sum from last chain element
- `out_data`, out, OUT_W: signed rounded sample at FIFO head
- `out_valid`, out, 1: FIFO not empty
- `out_ready`, in, 1: consumer accepts head this cycle
- `overflow`, out, 1: sticky; a result was dropped because the FIFO was full
- `sat`, out, 1: sticky; a result was clipped
- `drop_cnt`, out, 8: count of dropped results; saturates at 255

## Operation
- Valid tracking: a LAT-bit shift register is loaded with `in_valid` each cycle. Its tail bit `tag` marks `yin` as a real result in that cycle.
- Round/saturate, 1 register stage, applied when `tag`=1:
  - `s = (sext33(yin) + 2^(SHIFT-1)) >>> SHIFT`, arithmetic shift, round-half-up toward +inf.
  - If `s > 2^(OUT_W-1)-1`, clip to max and set `sat`.
  - If `s < -2^(OUT_W-1)`, clip to min and set `sat`.
- FIFO push: when the round stage holds a valid result.
  - Not full, or full with a pop in the same cycle: the result is written.
  - Otherwise the result is dropped, `overflow` is set and `drop_cnt` increments (saturating at 255).
- FIFO pop: `out_valid && out_ready`.
- `out_data` shows the head combinationally from FIFO storage (show-ahead). It holds its value while `out_valid`=1 and `out_ready`=0.
- `overflow`, `sat` and `drop_cnt` clear only on reset.

## Timing
- Reset (`rst`=0, async): valid shift register 0, round stage invalid and 0, FIFO empty, `out_valid`=0, `out_data`=0, `overflow`=0, `sat`=0, `drop_cnt`=0.
- Sum of a sample entered with `in_valid` at cycle t is sampled from `yin` at edge t+LAT.
- Rounded value is written to the FIFO at edge t+LAT+1; `out_valid` rises in cycle t+LAT+1 if the FIFO was empty.
- Throughput: one result per cycle sustained with `out_ready`=1.
- Empty FIFO with push: no same-cycle bypass; the sample appears one cycle after the round stage.
- Full FIFO with push and pop in the same cycle: both happen, count unchanged, no drop.
- Empty FIFO with `out_ready`=1: no effect.
- Reset asserted mid-stream: every in-flight tag and FIFO entry is discarded. The first valid result after release requires a fresh `in_valid`.
- Read/write pointers wrap modulo DEPTH. Full/empty is distinguished by an extra pointer bit.

## Structure
- Package `fir_pkg`:
  - constant `ACC_W`=32
  - function `round_sat(acc, shift, out_w)` returning `{sat_flag, value}`, shared with later decimator stages
- Sub-module `sync_fifo` (WIDTH, DEPTH):
  - ports: push/pop/full/empty/head
  - show-ahead head; push accepted when full if pop is asserted in the same cycle
- Top level holds the valid shift register, round stage, sticky flags and drop counter.

## Test plan
- Rounding: LAT=3, SHIFT=15, OUT_W=16, single `in_valid` pulses with `yin` at the tagged cycle:
  - 0x0000_4000 → 1
  - 0x0000_3FFF → 0
  - 0xFFFF_C000 → 0
  - 0xFFFF_BFFF → -1
  - `sat`=0 throughout
- Saturation:
  - `yin`=0x7FFF_FFFF → 32767
  - `yin`=0x8000_0000 → -32768
  - `sat` set after the first and stays 1
- Latency: `in_valid` at cycle 10, LAT=17 → `yin` sampled at edge 27, `out_valid` first high in cycle 28; untagged `yin` garbage never appears.
- Backpressure: DEPTH=4, `out_ready`=0, 6 consecutive valid results:
  - FIFO holds the first 4; `overflow`=1, `drop_cnt`=2
  - then `out_ready`=1 → exactly those 4 come out in order, then `out_valid`=0
- Full with simultaneous pop: FIFO full, `out_ready`=1 in the same cycle a result arrives → no drop, `drop_cnt` unchanged, order preserved.
- Async reset: assert `rst`=0 mid-edge while the FIFO holds 3 entries and tags are in flight → all outputs 0 immediately. After release with no `in_valid`, `out_valid` stays 0 for LAT+5 cycles.
